// File: rtl/ula_ctrl_fsm.sv
// Multicycle control sequencer for the ALU operand path: fetch, decode and
// execute phases with counted wait states for memory and the mult/div unit.
module ula_ctrl_fsm #(
  parameter int MEM_WAIT      = 1,
  parameter int MULDIV_CYCLES = 32
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       alu_zero,
  output logic [1:0] ula_a_sel,
  output logic [1:0] ula_b_sel,
  output logic [2:0] ula_op,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       pc_write,
  output logic       pc_src,
  output logic       alu_out_write,
  output logic       reg_write,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       muldiv_start,
  output logic       illegal_op,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    FETCH      = 4'd0,
    DECODE     = 4'd1,
    EXEC_R     = 4'd2,
    EXEC_SHIFT = 4'd3,
    EXEC_I     = 4'd4,
    MEM_ADDR   = 4'd5,
    MEM_ACCESS = 4'd6,
    BRANCH     = 4'd7,
    MULDIV     = 4'd8,
    WRITEBACK  = 4'd9
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2b;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;

  localparam logic [5:0] MEM_LAST = 6'(MEM_WAIT);
  localparam logic [5:0] MD_LAST  = 6'(MULDIV_CYCLES - 1);

  state_e     state_q, state_d;
  logic [5:0] cnt_q, cnt_d;

  logic is_rtype, is_r_arith, is_r_shift, is_r_muldiv;

  assign is_rtype    = (opcode == OP_RTYPE);
  assign is_r_arith  = is_rtype && (funct == 6'h20 || funct == 6'h22 || funct == 6'h24);
  assign is_r_shift  = is_rtype && (funct == 6'h00 || funct == 6'h02 || funct == 6'h03);
  assign is_r_muldiv = is_rtype && (funct == 6'h18 || funct == 6'h1a);

  always_comb begin
    // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latch).
    state_d = FETCH;
    case (state_q)
      FETCH:      state_d = (cnt_q == MEM_LAST) ? DECODE : FETCH;
      DECODE: begin
        if (is_r_arith)                          state_d = EXEC_R;
        else if (is_r_shift)                     state_d = EXEC_SHIFT;
        else if (is_r_muldiv)                    state_d = MULDIV;
        else if (opcode == OP_ADDI)              state_d = EXEC_I;
        else if (opcode == OP_LW || opcode == OP_SW)  state_d = MEM_ADDR;
        else if (opcode == OP_BEQ || opcode == OP_BNE) state_d = BRANCH;
        else                                     state_d = FETCH;
      end
      EXEC_R, EXEC_SHIFT, EXEC_I: state_d = WRITEBACK;
      MEM_ADDR:   state_d = MEM_ACCESS;
      MEM_ACCESS: begin
        if (cnt_q != MEM_LAST)     state_d = MEM_ACCESS;
        else if (opcode == OP_LW)  state_d = WRITEBACK;
        else                       state_d = FETCH;
      end
      MULDIV:     state_d = (cnt_q == MD_LAST) ? FETCH : MULDIV;
      default:    state_d = FETCH;
    endcase
    cnt_d = (state_d == state_q) ? cnt_q + 6'd1 : 6'd0;
  end

  always_ff @(posedge clk or posedge reset) begin
    // NOTE: non-blocking assignments so every flop samples pre-edge values.
    if (reset) begin
      state_q <= FETCH;
      cnt_q   <= 6'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Outputs are decoded from the current state; reset forces all of them low.
  always_comb begin
    ula_a_sel     = 2'b00;
    ula_b_sel     = 2'b00;
    ula_op        = 3'b000;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    pc_write      = 1'b0;
    pc_src        = 1'b0;
    alu_out_write = 1'b0;
    reg_write     = 1'b0;
    reg_dst       = 1'b0;
    mem_to_reg    = 1'b0;
    muldiv_start  = 1'b0;
    illegal_op    = 1'b0;
    if (!reset) begin
      case (state_q)
        FETCH: begin
          mem_read  = 1'b1;
          ula_b_sel = 2'b01;
          ula_op    = 3'b001;
          ir_write  = (cnt_q == MEM_LAST);
          pc_write  = (cnt_q == MEM_LAST);
        end
        DECODE: begin
          ula_b_sel     = 2'b11;
          ula_op        = 3'b001;
          alu_out_write = 1'b1;
          illegal_op    = (state_d == FETCH);
        end
        EXEC_R: begin
          ula_a_sel     = 2'b01;
          alu_out_write = 1'b1;
          case (funct)
            6'h20:   ula_op = 3'b001;
            6'h22:   ula_op = 3'b010;
            6'h24:   ula_op = 3'b011;
            default: ula_op = 3'b000;
          endcase
        end
        EXEC_SHIFT: begin
          ula_a_sel     = 2'b10;
          alu_out_write = 1'b1;
        end
        EXEC_I, MEM_ADDR: begin
          ula_a_sel     = 2'b01;
          ula_b_sel     = 2'b10;
          ula_op        = 3'b001;
          alu_out_write = 1'b1;
        end
        MEM_ACCESS: begin
          mem_read  = (opcode == OP_LW);
          mem_write = (opcode == OP_SW);
        end
        BRANCH: begin
          ula_a_sel = 2'b01;
          ula_op    = 3'b010;
          pc_src    = 1'b1;
          pc_write  = ((opcode == OP_BEQ) && alu_zero) || ((opcode == OP_BNE) && !alu_zero);
        end
        MULDIV: begin
          ula_a_sel    = 2'b01;
          muldiv_start = (cnt_q == 6'd0);
        end
        WRITEBACK: begin
          reg_write  = 1'b1;
          reg_dst    = is_rtype;
          mem_to_reg = (opcode == OP_LW);
        end
        default: ;
      endcase
    end
  end

  assign state = state_q;

endmodule

// File: tb/tb_ula_ctrl_fsm.sv
// Scoreboard bench for ula_ctrl_fsm: the stimulus pushes one expected output
// vector per cycle, and a negedge monitor pops and compares it.
module tb_ula_ctrl_fsm;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] opcode, funct;
  logic       alu_zero;
  logic [1:0] ula_a_sel, ula_b_sel;
  logic [2:0] ula_op;
  logic       mem_read, mem_write, ir_write, pc_write, pc_src, alu_out_write;
  logic       reg_write, reg_dst, mem_to_reg, muldiv_start, illegal_op;
  logic [3:0] state;

  always #5 clk = ~clk;

  ula_ctrl_fsm #(.MEM_WAIT(1), .MULDIV_CYCLES(32)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .alu_zero(alu_zero),
    .ula_a_sel(ula_a_sel), .ula_b_sel(ula_b_sel), .ula_op(ula_op),
    .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
    .pc_write(pc_write), .pc_src(pc_src), .alu_out_write(alu_out_write),
    .reg_write(reg_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
    .muldiv_start(muldiv_start), .illegal_op(illegal_op), .state(state)
  );

  typedef struct packed {
    logic [3:0]  st;
    logic [1:0]  a;
    logic [1:0]  b;
    logic [2:0]  op;
    logic [10:0] s;
  } vec_t;

  typedef struct {
    vec_t  v;
    string tag;
  } item_t;

  // Strobe bits inside vec_t.s
  localparam logic [10:0] S_MR  = 11'h001, S_MW  = 11'h002, S_IRW = 11'h004,
                          S_PCW = 11'h008, S_PCS = 11'h010, S_AOW = 11'h020,
                          S_RW  = 11'h040, S_RD  = 11'h080, S_MTR = 11'h100,
                          S_MDS = 11'h200, S_ILL = 11'h400;

  item_t q[$];
  int    compared   = 0;
  int    mismatched = 0;
  vec_t  got;

  always_comb begin
    got = {state, ula_a_sel, ula_b_sel, ula_op,
           {illegal_op, muldiv_start, mem_to_reg, reg_dst, reg_write, alu_out_write,
            pc_src, pc_write, ir_write, mem_write, mem_read}};
  end

  always @(negedge clk) begin
    if (q.size() > 0) begin
      item_t it;
      it = q.pop_front();
      compared++;
      if (got !== it.v) begin
        mismatched++;
        $display("FAIL %s: got st=%0d a=%b b=%b op=%b s=%h, expected st=%0d a=%b b=%b op=%b s=%h",
                 it.tag, got.st, got.a, got.b, got.op, got.s,
                 it.v.st, it.v.a, it.v.b, it.v.op, it.v.s);
      end
    end
  end

  // Push the expectation for the current cycle, then advance to just after the next edge.
  task automatic cyc(input logic [3:0] st, input logic [1:0] a, input logic [1:0] b,
                     input logic [2:0] op, input logic [10:0] s, input string tag);
    item_t it;
    it.v   = {st, a, b, op, s};
    it.tag = tag;
    q.push_back(it);
    @(posedge clk);
    #1;
  endtask

  task automatic fetch();
    cyc(4'd0, 2'b00, 2'b01, 3'b001, S_MR, "fetch1");
    cyc(4'd0, 2'b00, 2'b01, 3'b001, S_MR | S_IRW | S_PCW, "fetch2");
  endtask

  task automatic decode();
    cyc(4'd1, 2'b00, 2'b11, 3'b001, S_AOW, "decode");
  endtask

  task automatic set_instr(input logic [5:0] op, input logic [5:0] fn, input logic z);
    opcode   = op;
    funct    = fn;
    alu_zero = z;
  endtask

  initial begin
    reset = 1'b1;
    set_instr(6'h00, 6'h00, 1'b0);
    @(posedge clk);
    #1;
    cyc(4'd0, 2'b00, 2'b00, 3'b000, 11'h000, "reset_hold");
    reset = 1'b0;

    // R-type arithmetic: add, sub, and
    set_instr(6'h00, 6'h20, 1'b0);
    fetch(); decode();
    cyc(4'd2, 2'b01, 2'b00, 3'b001, S_AOW, "add_exec");
    cyc(4'd9, 2'b00, 2'b00, 3'b000, S_RW | S_RD, "add_wb");
    set_instr(6'h00, 6'h22, 1'b0);
    fetch(); decode();
    cyc(4'd2, 2'b01, 2'b00, 3'b010, S_AOW, "sub_exec");
    cyc(4'd9, 2'b00, 2'b00, 3'b000, S_RW | S_RD, "sub_wb");
    set_instr(6'h00, 6'h24, 1'b0);
    fetch(); decode();
    cyc(4'd2, 2'b01, 2'b00, 3'b011, S_AOW, "and_exec");
    cyc(4'd9, 2'b00, 2'b00, 3'b000, S_RW | S_RD, "and_wb");

    // Shift and immediate
    set_instr(6'h00, 6'h02, 1'b0);
    fetch(); decode();
    cyc(4'd3, 2'b10, 2'b00, 3'b000, S_AOW, "shift_exec");
    cyc(4'd9, 2'b00, 2'b00, 3'b000, S_RW | S_RD, "shift_wb");
    set_instr(6'h08, 6'h00, 1'b0);
    fetch(); decode();
    cyc(4'd4, 2'b01, 2'b10, 3'b001, S_AOW, "addi_exec");
    cyc(4'd9, 2'b00, 2'b00, 3'b000, S_RW, "addi_wb");

    // Load and store with one memory wait state
    set_instr(6'h23, 6'h00, 1'b0);
    fetch(); decode();
    cyc(4'd5, 2'b01, 2'b10, 3'b001, S_AOW, "lw_addr");
    cyc(4'd6, 2'b00, 2'b00, 3'b000, S_MR, "lw_mem1");
    cyc(4'd6, 2'b00, 2'b00, 3'b000, S_MR, "lw_mem2");
    cyc(4'd9, 2'b00, 2'b00, 3'b000, S_RW | S_MTR, "lw_wb");
    set_instr(6'h2b, 6'h00, 1'b0);
    fetch(); decode();
    cyc(4'd5, 2'b01, 2'b10, 3'b001, S_AOW, "sw_addr");
    cyc(4'd6, 2'b00, 2'b00, 3'b000, S_MW, "sw_mem1");
    cyc(4'd6, 2'b00, 2'b00, 3'b000, S_MW, "sw_mem2");

    // Branches: beq/bne with both zero-flag values
    set_instr(6'h04, 6'h00, 1'b1);
    fetch(); decode();
    cyc(4'd7, 2'b01, 2'b00, 3'b010, S_PCS | S_PCW, "beq_taken");
    set_instr(6'h04, 6'h00, 1'b0);
    fetch(); decode();
    cyc(4'd7, 2'b01, 2'b00, 3'b010, S_PCS, "beq_not_taken");
    set_instr(6'h05, 6'h00, 1'b1);
    fetch(); decode();
    cyc(4'd7, 2'b01, 2'b00, 3'b010, S_PCS, "bne_not_taken");
    set_instr(6'h05, 6'h00, 1'b0);
    fetch(); decode();
    cyc(4'd7, 2'b01, 2'b00, 3'b010, S_PCS | S_PCW, "bne_taken");

    // mult: start pulse once, state held 32 cycles
    set_instr(6'h00, 6'h18, 1'b0);
    fetch(); decode();
    cyc(4'd8, 2'b01, 2'b00, 3'b000, S_MDS, "mult_start");
    for (int i = 1; i < 32; i++) cyc(4'd8, 2'b01, 2'b00, 3'b000, 11'h000, "mult_hold");

    // Illegal opcode and illegal R-type funct
    set_instr(6'h3f, 6'h00, 1'b0);
    fetch();
    cyc(4'd1, 2'b00, 2'b11, 3'b001, S_AOW | S_ILL, "illegal_op");
    set_instr(6'h00, 6'h3f, 1'b0);
    fetch();
    cyc(4'd1, 2'b00, 2'b11, 3'b001, S_AOW | S_ILL, "illegal_funct");

    // Reset asserted mid-MULDIV at cnt==10, checked before any clock edge
    set_instr(6'h00, 6'h1a, 1'b0);
    fetch(); decode();
    cyc(4'd8, 2'b01, 2'b00, 3'b000, S_MDS, "div_start");
    for (int i = 1; i < 10; i++) cyc(4'd8, 2'b01, 2'b00, 3'b000, 11'h000, "div_hold");
    reset = 1'b1;
    cyc(4'd0, 2'b00, 2'b00, 3'b000, 11'h000, "reset_async");
    reset = 1'b0;
    fetch(); decode();
    cyc(4'd8, 2'b01, 2'b00, 3'b000, S_MDS, "div_restart");

    for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
    #1;
    if (q.size() > 0) begin
      compared++;
      mismatched++;
      $display("FAIL drain: %0d expectations left, expected 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
